step_dir_rx: RTL and testbench

- Receive-side counterpart of the step/dir pulse generator. Decodes an external step/dir pair into a signed 32-bit position and a per-window signed step-rate measurement.
- Use cases: closed-loop checking of generator outputs, or following an external step/dir source (slave axis).
- Provides pulse-width filtering, dir-setup checking and sticky error flags. Sits beside the step generator on the same clock domain.

---
 rtl/step_dir_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_step_dir_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_dir_rx.sv
// step_dir_rx
//   Receive-side step/dir decoder. Synchronizes an external step/dir pair,
//   qualifies step pulses by minimum high width, checks dir setup and
//   stability, and maintains a signed 32-bit position plus a per-window
//   signed step-rate measurement.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   step_in        asynchronous step input
//   dir_in         asynchronous dir input (0 = +1 count, 1 = -1 count)
//   set_position   load position from data_in (wins over a coincident step)
//   data_in        signed position load value
//   clear_err      clears the sticky error flags
//   position       signed accumulated position (wraps naturally)
//   step_strobe    one-cycle pulse per accepted step
//   step_dir       dir latched for the most recent accepted step
//   velocity       signed net steps counted in the last completed window
//   velocity_valid one-cycle pulse when velocity updates
//   glitch_err     sticky: high pulse shorter than MIN_HIGH seen
//   dir_err        sticky: dir setup violated or dir changed while step high
module step_dir_rx #(
    parameter int unsigned MIN_HIGH  = 50,
    parameter int unsigned DIR_SETUP = 50,
    parameter int unsigned WINDOW    = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step_in,
    input  logic               dir_in,
    input  logic               set_position,
    input  logic signed [31:0] data_in,
    input  logic               clear_err,
    output logic signed [31:0] position,
    output logic               step_strobe,
    output logic               step_dir,
    output logic signed [31:0] velocity,
    output logic               velocity_valid,
    output logic               glitch_err,
    output logic               dir_err
);

    localparam int HW = $clog2(MIN_HIGH + 1);
    localparam int DW = $clog2(DIR_SETUP + 1);
    localparam int WW = $clog2(WINDOW);

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        QUAL = 2'd1,
        HIGH = 2'd2
    } state_t;

    // Synchronizers and dir change detection
    logic step_m, step_s;
    logic dir_m, dir_s, dir_d;
    logic dir_chg;

    // The sync chain is cleared by reset, so a pulse already high at reset
    // release would look like a fresh rising edge. 'armed' only rises once
    // the chain has refilled and step_s has been seen low.
    logic [1:0] fill;
    logic       armed;

    logic [DW-1:0] dcnt;

    state_t        state, state_nx;
    logic [HW-1:0] hcnt, hcnt_nx;
    logic          cap_dir, cap_dir_nx;
    logic          accept, glitch_ev, dir_ev;

    logic [WW-1:0]      wcnt;
    logic signed [31:0] win_acc;
    logic signed [31:0] strobe_delta;

    assign dir_chg = (dir_s != dir_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            step_m <= 1'b0;
            step_s <= 1'b0;
            dir_m  <= 1'b0;
            dir_s  <= 1'b0;
            dir_d  <= 1'b0;
            fill   <= '0;
            armed  <= 1'b0;
        end else begin
            step_m <= step_in;
            step_s <= step_m;
            dir_m  <= dir_in;
            dir_s  <= dir_m;
            dir_d  <= dir_s;
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end
            if (fill == 2'd2 && !step_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Dir stability counter, saturating at DIR_SETUP
    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt <= '0;
        end else if (dir_chg) begin
            dcnt <= '0;
        end else if (dcnt != DW'(DIR_SETUP)) begin
            dcnt <= dcnt + 1'b1;
        end
    end

    // Pulse qualification FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOW;
            hcnt    <= '0;
            cap_dir <= 1'b0;
        end else begin
            state   <= state_nx;
            hcnt    <= hcnt_nx;
            cap_dir <= cap_dir_nx;
        end
    end

    // Pulse qualification FSM: next state and events
    always_comb begin
        state_nx   = state;
        hcnt_nx    = hcnt;
        cap_dir_nx = cap_dir;
        accept     = 1'b0;
        glitch_ev  = 1'b0;
        dir_ev     = 1'b0;
        case (state)
            LOW: begin
                if (step_s && armed) begin
                    state_nx   = QUAL;
                    hcnt_nx    = HW'(1);
                    cap_dir_nx = dir_s;
                    if (dcnt < DW'(DIR_SETUP)) begin
                        dir_ev = 1'b1;
                    end
                end
            end
            QUAL: begin
                if (!step_s) begin
                    state_nx  = LOW;
                    glitch_ev = 1'b1;
                end else if (hcnt == HW'(MIN_HIGH - 1)) begin
                    state_nx = HIGH;
                    accept   = 1'b1;
                    hcnt_nx  = hcnt + 1'b1;
                end else begin
                    hcnt_nx = hcnt + 1'b1;
                end
            end
            HIGH: begin
                if (!step_s) begin
                    state_nx = LOW;
                end
            end
            default: begin
                state_nx = LOW;
            end
        endcase
        if (state != LOW && dir_chg) begin
            dir_ev = 1'b1;
        end
    end

    // Position, strobe and latched dir
    always_ff @(posedge clk) begin
        if (reset) begin
            position    <= '0;
            step_strobe <= 1'b0;
            step_dir    <= 1'b0;
        end else begin
            step_strobe <= accept;
            if (accept) begin
                step_dir <= cap_dir;
            end
            if (set_position) begin
                position <= data_in;
            end else if (accept) begin
                position <= cap_dir ? position - 32'sd1 : position + 32'sd1;
            end
        end
    end

    // Sticky error flags: a new event in the clearing cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_err <= 1'b0;
            dir_err    <= 1'b0;
        end else begin
            glitch_err <= (glitch_err & ~clear_err) | glitch_ev;
            dir_err    <= (dir_err & ~clear_err) | dir_ev;
        end
    end

    // Velocity window: the strobe visible on the last window cycle is
    // folded straight into the reported velocity.
    always_comb begin
        strobe_delta = '0;
        if (step_strobe) begin
            strobe_delta = step_dir ? -32'sd1 : 32'sd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt           <= '0;
            win_acc        <= '0;
            velocity       <= '0;
            velocity_valid <= 1'b0;
        end else if (wcnt == WW'(WINDOW - 1)) begin
            wcnt           <= '0;
            win_acc        <= '0;
            velocity       <= win_acc + strobe_delta;
            velocity_valid <= 1'b1;
        end else begin
            wcnt           <= wcnt + 1'b1;
            win_acc        <= win_acc + strobe_delta;
            velocity_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_step_dir_rx.sv
// tb_step_dir_rx
//   Directed, table-driven bench for step_dir_rx with MIN_HIGH=50,
//   DIR_SETUP=50, WINDOW=1000, plus hand-written multi-cycle sequences.
module tb_step_dir_rx;

    localparam int WINDOW = 1000;

    logic               clk = 1'b0;
    logic               reset;
    logic               step_in;
    logic               dir_in;
    logic               set_position;
    logic signed [31:0] data_in;
    logic               clear_err;
    logic signed [31:0] position;
    logic               step_strobe;
    logic               step_dir;
    logic signed [31:0] velocity;
    logic               velocity_valid;
    logic               glitch_err;
    logic               dir_err;

    step_dir_rx #(
        .MIN_HIGH (50),
        .DIR_SETUP(50),
        .WINDOW   (WINDOW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .step_in       (step_in),
        .dir_in        (dir_in),
        .set_position  (set_position),
        .data_in       (data_in),
        .clear_err     (clear_err),
        .position      (position),
        .step_strobe   (step_strobe),
        .step_dir      (step_dir),
        .velocity      (velocity),
        .velocity_valid(velocity_valid),
        .glitch_err    (glitch_err),
        .dir_err       (dir_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Observation scoreboard: counts strobes and rebuilds each window's
    // net step count from the strobes it sees.
    int n_str = 0;
    int acc   = 0;
    int since = 0;
    int n_log = 0;
    int vel_log [0:31];

    always @(posedge clk) begin
        #1;
        if (reset) begin
            acc   = 0;
            since = 0;
            n_log = 0;
        end else begin
            since++;
            if (step_strobe) n_str++;
            if (velocity_valid) begin
                chk("vel_window", velocity, acc);
                chk("vel_period", since, WINDOW);
                if (n_log < 32) vel_log[n_log] = velocity;
                n_log++;
                since = 0;
                acc   = 0;
            end
            if (step_strobe) acc += step_dir ? -1 : 1;
        end
    end

    task automatic pulse(input logic d, input int setup, input int hi, input int lo);
        dir_in = d;
        repeat (setup) @(negedge clk);
        step_in = 1'b1;
        repeat (hi) @(negedge clk);
        step_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    typedef struct {
        logic        dir;
        int          setup;
        int          hi;
        logic        ld;
        logic [31:0] ldv;
        logic        clr;
        logic [31:0] pos;
        int          nstr;
        logic        sdir;
        logic        gl;
        logic        de;
    } vec_t;

    function automatic vec_t mk(input logic dir, input int setup, input int hi,
                                input logic ld, input logic [31:0] ldv, input logic clr,
                                input logic [31:0] pos, input int nstr, input logic sdir,
                                input logic gl, input logic de);
        vec_t v;
        v.dir = dir; v.setup = setup; v.hi = hi; v.ld = ld; v.ldv = ldv; v.clr = clr;
        v.pos = pos; v.nstr = nstr; v.sdir = sdir; v.gl = gl; v.de = de;
        return v;
    endfunction

    vec_t tbl [20];
    int   s0;

    initial begin
        for (int i = 0; i < 10; i++)
            tbl[i] = mk(1'b0, 100, 300, 1'b0, 32'd0, 1'b0, 32'(i + 1), 1, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 100, 300, 1'b1, -32'sd5, 1'b0, -32'sd6, 1, 1'b1, 1'b0, 1'b0);
        tbl[11] = mk(1'b1, 100, 300, 1'b0, 32'd0,   1'b0, -32'sd7, 1, 1'b1, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 100, 300, 1'b0, 32'd0,   1'b0, -32'sd8, 1, 1'b1, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 100, 49,  1'b0, 32'd0,   1'b0, -32'sd8, 0, 1'b1, 1'b1, 1'b0);
        tbl[14] = mk(1'b0, 100, 50,  1'b0, 32'd0,   1'b0, -32'sd7, 1, 1'b0, 1'b1, 1'b0);
        tbl[15] = mk(1'b0, 100, 300, 1'b0, 32'd0,   1'b1, -32'sd6, 1, 1'b0, 1'b0, 1'b0);
        tbl[16] = mk(1'b1, 10,  300, 1'b0, 32'd0,   1'b0, -32'sd7, 1, 1'b1, 1'b0, 1'b1);
        tbl[17] = mk(1'b1, 100, 300, 1'b0, 32'd0,   1'b1, -32'sd8, 1, 1'b1, 1'b0, 1'b0);
        tbl[18] = mk(1'b0, 100, 300, 1'b1, 32'h7FFF_FFFF, 1'b0, 32'h8000_0000, 1, 1'b0, 1'b0, 1'b0);
        tbl[19] = mk(1'b1, 100, 300, 1'b1, 32'h8000_0000, 1'b0, 32'h7FFF_FFFF, 1, 1'b1, 1'b0, 1'b0);

        reset = 1'b1; step_in = 1'b0; dir_in = 1'b0;
        set_position = 1'b0; data_in = '0; clear_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_position", position, 32'd0);
        chk("rst_velocity", velocity, 32'd0);
        chk("rst_strobe", 32'(step_strobe), 32'd0);
        chk("rst_vvalid", 32'(velocity_valid), 32'd0);
        chk("rst_step_dir", 32'(step_dir), 32'd0);
        chk("rst_glitch", 32'(glitch_err), 32'd0);
        chk("rst_dir_err", 32'(dir_err), 32'd0);
        reset = 1'b0;
        repeat (100) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            if (tbl[i].ld) begin
                set_position = 1'b1; data_in = tbl[i].ldv;
                @(negedge clk);
                set_position = 1'b0;
            end
            if (tbl[i].clr) begin
                clear_err = 1'b1;
                @(negedge clk);
                clear_err = 1'b0;
            end
            s0 = n_str;
            pulse(tbl[i].dir, tbl[i].setup, tbl[i].hi, 200);
            chk($sformatf("v%0d_position", i), position, tbl[i].pos);
            chk($sformatf("v%0d_strobes", i), n_str - s0, tbl[i].nstr);
            chk($sformatf("v%0d_step_dir", i), 32'(step_dir), 32'(tbl[i].sdir));
            chk($sformatf("v%0d_glitch", i), 32'(glitch_err), 32'(tbl[i].gl));
            chk($sformatf("v%0d_dir_err", i), 32'(dir_err), 32'(tbl[i].de));
        end

        // Load coinciding with the acceptance edge (52nd edge after step rise)
        s0 = n_str;
        step_in = 1'b1;
        repeat (51) @(negedge clk);
        set_position = 1'b1; data_in = 32'sd100;
        @(negedge clk);
        set_position = 1'b0;
        chk("load_vs_step_position", position, 32'sd100);
        chk("load_vs_step_strobe", 32'(step_strobe), 32'd1);
        repeat (200) @(negedge clk);
        step_in = 1'b0;
        repeat (200) @(negedge clk);
        chk("load_vs_step_hold", position, 32'sd100);
        chk("load_vs_step_count", n_str - s0, 32'd1);

        // Dir toggled while the pulse is still qualifying
        s0 = n_str;
        dir_in = 1'b0;
        repeat (100) @(negedge clk);
        step_in = 1'b1;
        repeat (20) @(negedge clk);
        dir_in = 1'b1;
        repeat (280) @(negedge clk);
        step_in = 1'b0;
        repeat (200) @(negedge clk);
        chk("midpulse_position", position, 32'sd101);
        chk("midpulse_step_dir", 32'(step_dir), 32'd0);
        chk("midpulse_dir_err", 32'(dir_err), 32'd1);
        chk("midpulse_count", n_str - s0, 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        @(negedge clk);
        chk("clear_dir_err", 32'(dir_err), 32'd0);

        // Strobe landing on the last cycle of a window
        dir_in = 1'b0;
        repeat (100) @(negedge clk);
        for (int i = 0; i < 1100 && !velocity_valid; i++) @(negedge clk);
        chk("win_sync_seen", 32'(velocity_valid), 32'd1);
        repeat (947) @(negedge clk);
        step_in = 1'b1;
        repeat (52) @(negedge clk);
        chk("win_edge_strobe", 32'(step_strobe), 32'd1);
        @(negedge clk);
        chk("win_edge_vvalid", 32'(velocity_valid), 32'd1);
        chk("win_edge_velocity", velocity, 32'sd1);
        repeat (100) @(negedge clk);
        step_in = 1'b0;
        repeat (200) @(negedge clk);

        // Velocity from reset: +1 every 100 cycles, then -1 every 200 cycles
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        dir_in = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 20; i++) pulse(1'b0, 0, 60, 40);
        for (int i = 0; i < 30; i++) pulse(1'b1, 0, 60, 140);
        chk("vel_log_count", 32'(n_log >= 7), 32'd1);
        if (n_log >= 7) begin
            chk("vel_first", vel_log[0], 32'sd10);
            chk("vel_second", vel_log[1], 32'sd10);
            for (int i = 2; i < 7; i++)
                chk($sformatf("vel_steady%0d", i), vel_log[i], -32'sd5);
        end

        // Reset in the middle of a qualifying pulse
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        dir_in = 1'b0;
        repeat (100) @(negedge clk);
        s0 = n_str;
        step_in = 1'b1;
        repeat (32) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_position0", position, 32'd0);
        repeat (150) @(negedge clk);
        chk("midrst_position1", position, 32'd0);
        step_in = 1'b0;
        repeat (100) @(negedge clk);
        chk("midrst_position2", position, 32'd0);
        chk("midrst_count", n_str - s0, 32'd0);
        chk("midrst_glitch", 32'(glitch_err), 32'd0);
        pulse(1'b0, 100, 100, 100);
        chk("midrst_next_pulse", position, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
